instruction_fetch_unit: RTL

//  Upstream neighbour of the instruction register in the multi-cycle RISC CPU.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_register.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the multi-cycle CPU front end.
// The fetch FSM states and the default reset PC live here so every stage agrees on them.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: synchronous reset to RESET_PC, then load, increment or hold.
// A load takes priority over an increment so redirects replace the step.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_value,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Increment wraps modulo 2^32 by construction of the adder width.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_value;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, handshakes with instruction memory and
// strobes each fetched word into the instruction register; accepts branch/jump redirects.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_value,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] Instruction_In,
  output logic               IR_Write,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               fetch_busy,
  output logic               fetch_err
);

  fetch_state_t       r_state;
  logic               r_mem_req;
  logic [INSTR_W-1:0] r_instr;
  logic               r_ir_write;
  logic               r_busy;
  logic               r_fetch_err;
  logic               r_pend_valid;
  logic [ADDR_W-1:0]  r_pend_addr;

  logic              w_load_ok;
  logic              w_load_bad;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_target;
  logic              w_pc_load;
  logic              w_pc_inc;
  logic [ADDR_W-1:0] w_pc;

  assign w_load_ok  = pc_load && is_word_aligned(pc_load_value);
  assign w_load_bad = pc_load && !is_word_aligned(pc_load_value);

  // A redirect arriving in the same cycle as the data counts, and beats an older pending one.
  assign w_redirect        = w_load_ok || r_pend_valid;
  assign w_redirect_target = w_load_ok ? pc_load_value : r_pend_addr;

  assign w_pc_load = ((r_state == IDLE) && w_load_ok) ||
                     ((r_state == WAIT) && mem_rvalid && w_redirect) ||
                     ((r_state == DONE) && w_redirect);
  assign w_pc_inc  = (r_state == DONE) && !w_redirect;

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_register (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_pc_load),
    .i_load_value (w_redirect_target),
    .i_inc        (w_pc_inc),
    .o_pc         (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_instr      <= '0;
      r_ir_write   <= 1'b0;
      r_busy       <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
    end else begin
      r_fetch_err <= w_load_bad;
      r_ir_write  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (fetch_start) begin
            r_state   <= REQ;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        REQ: begin
          if (w_load_ok) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= pc_load_value;
          end
          if (mem_ready) begin
            r_state   <= WAIT;
            r_mem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (w_redirect) begin
              // Word belongs to the abandoned path: drop it and go straight back to IDLE.
              r_state      <= IDLE;
              r_busy       <= 1'b0;
              r_pend_valid <= 1'b0;
            end else begin
              r_state    <= DONE;
              r_instr    <= mem_rdata;
              r_ir_write <= 1'b1;
            end
          end else if (w_load_ok) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= pc_load_value;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_pend_valid <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req        = r_mem_req;
  assign mem_addr       = w_pc;
  assign pc_out         = w_pc;
  assign Instruction_In = r_instr;
  assign IR_Write       = r_ir_write;
  assign fetch_busy     = r_busy;
  assign fetch_err      = r_fetch_err;

endmodule
